mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory-access stage directly downstream of the execute stage. Consumes the EX result (address or ALU value),
//  rs2 store data, funct3 and the forwarded control bits (memread/memwrite/memtoreg/regwrite).
//  Runs one data-bus transaction per load/store through a req/ack handshake; sizes and sign-extends load data.
//  Presents write-back data to the WB stage; stalls the pipeline while the bus is busy.
// PARAMETERS
//  XLEN         32   datapath width (tracks `XLEN)
//  ACK_TIMEOUT  16   max cycles in BUSY awaiting i_bus_ack before bus error; legal range 2..255
// PORTS
//  i_clk        in   1     clock
//  i_rst        in   1     reset, synchronous, active-low
//  i_valid      in   1     EX/MEM register holds a live instruction
//  i_res        in   XLEN  EX result: effective address for loads/stores, ALU value otherwise
//  i_rs2        in   XLEN  store data
//  i_f3         in   3     access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_memread    in   1     load
//  i_memwrite   in   1     store
//  i_memtoreg   in   1     WB selects load data instead of i_res
//  i_regwrite   in   1     forwarded write-enable
//  o_bus_req    out  1     bus request, registered
//  o_bus_we     out  1     1 = write
//  o_bus_addr   out  XLEN  word-aligned address ({i_res[XLEN-1:2],2'b00}), registered
//  o_bus_wdata  out  XLEN  store data, lane-replicated, registered
//  o_bus_be     out  4     byte enables, registered
//  i_bus_ack    in   1     transaction complete; i_bus_rdata valid in the same cycle
//  i_bus_rdata  in   XLEN  read data
//  o_wb_data    out  XLEN  write-back value
//  o_regwrite   out  1     i_regwrite gated: 0 while o_stall, 0 on error
//  o_stall      out  1     freeze IF..EX and the EX/MEM register
//  o_ex         out  1     one-cycle exception pulse: bus timeout or misaligned access (see CONFIGURATION)
// BEHAVIOUR
//  Reset (i_rst=0 at posedge): state IDLE; o_bus_req, o_bus_we, o_bus_be, o_ex and the load register all 0.
//   Applies mid-transaction: req drops at that edge; a late ack is ignored.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: start = i_valid & (i_memread|i_memwrite) & ~misaligned_trap.
//   o_stall = start (combinational). On start, register addr/wdata/be/we, assert o_bus_req, clear the
//   timeout counter, go to BUSY. Non-memory instructions pass through with zero latency:
//   o_wb_data = i_res, o_stall = 0.
//  BUSY: o_stall=1; o_bus_req held with stable addr/we/wdata/be.
//   On i_bus_ack: drop req; register the sized/extended load data; go to DONE.
//   Timeout: counter reaches ACK_TIMEOUT-1 with no ack -> drop req, load register=0, latch err, go to DONE.
//  DONE: o_stall=0, o_wb_data = i_memtoreg ? load_reg : i_res; o_regwrite = i_regwrite & ~err.
//   o_ex=1 if err. Unconditionally go to IDLE; i_valid is ignored (it is the same instruction), so no re-issue.
//  Ack in the same cycle req first rises: it cannot occur, because req is registered and the ack is sampled only in BUSY.
//  Acks seen in IDLE or DONE are ignored.
//  Load lanes, a=i_res[1:0]: B/BU -> byte a, H/HU -> half a[1]; sign- or zero-extend per f3[2]; W -> full word.
//  Stores:
//   SB -> be=4'b0001<<a, wdata={4{rs2[7:0]}}
//   SH -> be=a[1]?1100:0011, wdata={2{rs2[15:0]}}
//   SW -> be=1111, wdata=rs2
//  Loads: be=1111.
//  Undefined f3 (011,110,111) with memread/memwrite: treated as W.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//   - Misaligned access is H with a[0]=1, or W with a!=0.
//   - No bus request is issued; FSM goes IDLE -> DONE directly, o_stall=1 for that one cycle.
//   - In DONE, o_ex=1 and o_regwrite=0.
//  MEM_MISALIGN_TRAP_EN undefined:
//   - misaligned_trap is tied 0; the low address bits are ignored for lane selection beyond the rules above.
//   - H uses a[1] only; W uses the full word. No exception is raised.
// TESTING
//  1 ALU op, memtoreg=0, i_res=0x1234 -> o_wb_data=0x1234 same cycle, o_stall=0, no o_bus_req.
//  2 LB at 0x1003, ack after 3 cycles with rdata=0x80FFFFFF -> req 1 cycle after issue, stall 4 cycles,
//    DONE o_wb_data=0xFFFFFF80; LBU gives 0x00000080.
//  3 SH at 0x2002, rs2=0xDEADBEEF -> addr=0x2000, be=1100, wdata=0xBEEFBEEF, we=1; DONE o_regwrite=0.
//  4 LW, no ack (ACK_TIMEOUT=16) -> req high exactly 16 cycles, then o_ex pulse in DONE, o_wb_data=0, o_regwrite=0.
//  5 Reset asserted in BUSY, then ack 1 cycle later -> req=0 after the reset edge, state IDLE, no o_ex, ack ignored.
//  6 With MEM_MISALIGN_TRAP_EN: LW at 0x3001 -> no req, one stall cycle, o_ex=1, o_regwrite=0;
//    without it: normal LW at 0x3000.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-bus interface between the MEM stage (master) and the memory/bus fabric (slave).
// The request side is registered in the master and acknowledged by the slave with read data in the ack cycle.
interface mem_stage_if #(
  parameter int XLEN = 32
);
  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [3:0]      bus_be;
  logic            bus_ack;
  logic [XLEN-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: one req/ack bus transaction per load/store, load sizing/extension, WB data mux and stall.
// Optional feature macro MEM_MISALIGN_TRAP_EN: trap misaligned H/W accesses without issuing a bus request.
module mem_stage #(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_res,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [2:0]      i_f3,
  input  logic            i_memread,
  input  logic            i_memwrite,
  input  logic            i_memtoreg,
  input  logic            i_regwrite,
  mem_stage_if.master     bus,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_regwrite,
  output logic            o_stall,
  output logic            o_ex
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_e          state_q;
  logic [7:0]      cnt_q;
  logic            req_q, we_q, err_q, ex_q;
  logic [XLEN-1:0] addr_q, wdata_q, load_q;
  logic [3:0]      be_q;
  logic [1:0]      lane_q;
  logic [2:0]      f3_q;

  logic [1:0]      a;
  logic            mem_op, misaligned_trap, start;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d, load_d;
  logic [7:0]      rd_byte [4];
  logic [15:0]     rd_half;

  assign a      = i_res[1:0];
  assign mem_op = i_valid & (i_memread | i_memwrite);

`ifdef MEM_MISALIGN_TRAP_EN
  // f3[1:0]: 00 byte, 01 half, anything else is a word access
  assign misaligned_trap = mem_op & ((i_f3[1:0] == 2'b01) ? a[0]
                                                          : ((i_f3[1:0] != 2'b00) & (a != 2'b00)));
`else
  assign misaligned_trap = 1'b0;
`endif

  assign start = mem_op & ~misaligned_trap;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = i_rs2;
    if (i_memwrite) begin
      case (i_f3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << a;
          wdata_d = {(XLEN/8){i_rs2[7:0]}};
        end
        2'b01: begin
          be_d    = a[1] ? 4'b1100 : 4'b0011;
          wdata_d = {(XLEN/16){i_rs2[15:0]}};
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd_byte
      assign rd_byte[gi] = bus.bus_rdata[8*gi +: 8];
    end
  endgenerate

  assign rd_half = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];

  // Lane and size were captured at issue so sizing does not depend on the frozen EX/MEM inputs
  always_comb begin
    case (f3_q[1:0])
      2'b00:   load_d = f3_q[2] ? {{(XLEN-8){1'b0}}, rd_byte[lane_q]}
                                : {{(XLEN-8){rd_byte[lane_q][7]}}, rd_byte[lane_q]};
      2'b01:   load_d = f3_q[2] ? {{(XLEN-16){1'b0}}, rd_half}
                                : {{(XLEN-16){rd_half[15]}}, rd_half};
      default: load_d = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
      ex_q    <= 1'b0;
      lane_q  <= '0;
      f3_q    <= '0;
    end else begin
      ex_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= {i_res[XLEN-1:2], 2'b00};
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= i_memwrite;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            lane_q  <= a;
            f3_q    <= i_f3;
            err_q   <= 1'b0;
            state_q <= BUSY;
          end else if (misaligned_trap) begin
            load_q  <= '0;
            err_q   <= 1'b1;
            ex_q    <= 1'b1;
            state_q <= DONE;
          end
        end
        BUSY: begin
          // An ack on the final allowed cycle still completes the access
          if (bus.bus_ack) begin
            req_q   <= 1'b0;
            load_q  <= load_d;
            err_q   <= 1'b0;
            state_q <= DONE;
          end else if (cnt_q == TO_LAST) begin
            req_q   <= 1'b0;
            load_q  <= '0;
            err_q   <= 1'b1;
            ex_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_stall    = 1'b0;
    o_regwrite = i_regwrite;
    o_wb_data  = i_res;
    case (state_q)
      IDLE: begin
        o_stall    = mem_op;
        o_regwrite = i_regwrite & ~mem_op;
      end
      BUSY: begin
        o_stall    = 1'b1;
        o_regwrite = 1'b0;
      end
      DONE: begin
        o_wb_data  = i_memtoreg ? load_q : i_res;
        o_regwrite = i_regwrite & ~err_q;
      end
      default: ;
    endcase
  end

  assign o_ex          = ex_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_be    = be_q;

endmodule
